keypad_digit_emitter: RTL and testbench

- Converts a 32-bit unsigned binary value into decimal digits and streams them MSD-first, one digit per handshake.
- Digit encoding matches the keypad digit code: 8-bit value 0..9.
- Sits on the display/readback path. It turns a stored or accumulated code into a digit sequence for a display driver, or for replay into a keypad-style digit consumer.
- Conversion uses iterative double-dabble (shift-add-3); no divider.

---
 rtl/keypad_digit_emitter.sv | 131 +++++++++++++
 tb/tb_keypad_digit_emitter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_digit_emitter.sv
// Binary-to-decimal digit streamer: converts a 32-bit value with iterative double-dabble
// and hands out the decimal digits most-significant first over a valid/ready handshake.
module keypad_digit_emitter #(
    parameter bit PAD_ZEROS = 1'b0
) (
    input  logic        hwclk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] value,
    output logic        busy,
    output logic [7:0]  digit,
    output logic        digit_valid,
    input  logic        digit_ready,
    output logic        digit_last,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONVERT,
        S_ALIGN,
        S_EMIT
    } state_t;

    localparam int NUM_DIGITS = 10;

    state_t      state_q, state_d;
    logic [39:0] bcd_q, bcd_d;
    logic [31:0] shreg_q, shreg_d;
    logic [4:0]  shift_cnt_q, shift_cnt_d;
    logic [3:0]  digit_cnt_q, digit_cnt_d;
    logic        done_q, done_d;

    logic [39:0] bcd_adj;
    logic        top_nibble_zero;
    logic        emit_accept;
    logic        emit_is_last;

    // Add-3 correction applied to every BCD nibble before each shift.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5)
                                        ? (bcd_q[gi*4 +: 4] + 4'd3)
                                        : bcd_q[gi*4 +: 4];
        end
    endgenerate

    assign top_nibble_zero = (bcd_q[39:36] == 4'd0);
    assign emit_accept     = (state_q == S_EMIT) && digit_ready;
    assign emit_is_last    = (digit_cnt_q == 4'd1);

    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            bcd_q       <= '0;
            shreg_q     <= '0;
            shift_cnt_q <= '0;
            digit_cnt_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bcd_q       <= bcd_d;
            shreg_q     <= shreg_d;
            shift_cnt_q <= shift_cnt_d;
            digit_cnt_q <= digit_cnt_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bcd_d       = bcd_q;
        shreg_d     = shreg_q;
        shift_cnt_d = shift_cnt_q;
        digit_cnt_d = digit_cnt_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shreg_d     = value;
                    bcd_d       = '0;
                    shift_cnt_d = '0;
                    digit_cnt_d = 4'(NUM_DIGITS);
                    state_d     = S_CONVERT;
                end
            end

            S_CONVERT: begin
                {bcd_d, shreg_d} = {bcd_adj, shreg_q} << 1;
                shift_cnt_d      = shift_cnt_q + 5'd1;
                if (shift_cnt_q == 5'd31) begin
                    state_d = S_ALIGN;
                end
            end

            S_ALIGN: begin
                // Strip leading zeros one nibble per cycle, but always keep one digit.
                if (!PAD_ZEROS && top_nibble_zero && (digit_cnt_q > 4'd1)) begin
                    bcd_d       = {bcd_q[35:0], 4'd0};
                    digit_cnt_d = digit_cnt_q - 4'd1;
                end else begin
                    state_d = S_EMIT;
                end
            end

            S_EMIT: begin
                if (emit_accept) begin
                    bcd_d       = {bcd_q[35:0], 4'd0};
                    digit_cnt_d = digit_cnt_q - 4'd1;
                    if (emit_is_last) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy        = (state_q != S_IDLE);
    assign digit_valid = (state_q == S_EMIT);
    assign digit_last  = (state_q == S_EMIT) && emit_is_last;
    assign digit       = {4'd0, bcd_q[39:36]};
    assign done        = done_q;

endmodule

// File: tb/tb_keypad_digit_emitter.sv
// Self-checking bench for keypad_digit_emitter: one unpadded and one zero-padded instance,
// table vectors, hand-written corner sequences and random values against a decimal model.
module tb_keypad_digit_emitter;

    logic        hwclk;
    logic        reset;
    logic        start_s [2];
    logic [31:0] value_s [2];
    logic        ready_s [2];
    logic        busy_o  [2];
    logic [7:0]  digit_o [2];
    logic        valid_o [2];
    logic        last_o  [2];
    logic        done_o  [2];

    int tests;
    int fails;
    int exp_q[$];
    int got_q[$];
    int run_lat;

    typedef struct {
        logic [31:0] val;
        int          idx;
        int          rmode;
        bit          repulse;
        int          exp_n;
        int          exp_lat;
        int          exp_first;
    } vec_t;

    vec_t vecs[10];

    keypad_digit_emitter #(.PAD_ZEROS(1'b0)) dut0 (
        .hwclk(hwclk), .reset(reset), .start(start_s[0]), .value(value_s[0]),
        .busy(busy_o[0]), .digit(digit_o[0]), .digit_valid(valid_o[0]),
        .digit_ready(ready_s[0]), .digit_last(last_o[0]), .done(done_o[0])
    );

    keypad_digit_emitter #(.PAD_ZEROS(1'b1)) dut1 (
        .hwclk(hwclk), .reset(reset), .start(start_s[1]), .value(value_s[1]),
        .busy(busy_o[1]), .digit(digit_o[1]), .digit_valid(valid_o[1]),
        .digit_ready(ready_s[1]), .digit_last(last_o[1]), .done(done_o[1])
    );

    initial hwclk = 1'b0;
    always #5 hwclk = ~hwclk;

    task automatic check(input string name, input longint got, input longint exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Decimal digits by repeated division, MSD first.
    function automatic void build_exp(input logic [31:0] v, input bit pad);
        longint unsigned x;
        x = 64'(v);
        exp_q.delete();
        do begin
            exp_q.push_front(int'(x % 10));
            x = x / 10;
        end while (x != 0);
        if (pad) begin
            while (exp_q.size() < 10) exp_q.push_front(0);
        end
    endfunction

    // Entered and left just after a falling edge. rmode: 0 ready high, 1 fixed toggle
    // pattern, 2 random. repulse keeps poking start with 55 during CONVERT and EMIT.
    task automatic run_seq(input int idx, input logic [31:0] val, input int rmode,
                           input bit repulse, input string tag);
        int  n, vcount, hold_err, gap_err, last_err, busy_err, fmt_err, mism;
        bit  prev_stall, timeout, r;
        logic [7:0] prev_digit;
        logic prev_last;
        int  pat[6];
        pat = '{1, 0, 0, 1, 0, 1};
        build_exp(val, idx == 1);
        got_q.delete();
        run_lat = -1;
        n = -1; vcount = 0; hold_err = 0; gap_err = 0; last_err = 0;
        busy_err = 0; fmt_err = 0; mism = 0;
        prev_stall = 1'b0; timeout = 1'b1; prev_digit = '0; prev_last = 1'b0;
        start_s[idx] = 1'b1;
        value_s[idx] = val;
        ready_s[idx] = 1'b1;
        for (int k = 0; k < 400; k++) begin
            @(negedge hwclk);
            n++;
            if (done_o[idx]) begin
                timeout = 1'b0;
                break;
            end
            if (!busy_o[idx]) busy_err++;
            if (digit_o[idx][7:4] != 4'd0) fmt_err++;
            if (last_o[idx] && !valid_o[idx]) last_err++;
            if (prev_stall && (!valid_o[idx] || digit_o[idx] != prev_digit
                               || last_o[idx] != prev_last)) hold_err++;
            if (run_lat >= 0 && !valid_o[idx]) gap_err++;
            case (rmode)
                0:       r = 1'b1;
                1:       r = valid_o[idx] ? pat[vcount % 6] != 0 : 1'b1;
                default: r = 1'($urandom_range(0, 1));
            endcase
            if (valid_o[idx]) begin
                if (run_lat < 0) run_lat = n;
                vcount++;
                if (r) begin
                    got_q.push_back(int'(digit_o[idx][3:0]));
                    if (last_o[idx] != (got_q.size() == exp_q.size())) last_err++;
                end
            end
            prev_stall = valid_o[idx] && !r;
            prev_digit = digit_o[idx];
            prev_last  = last_o[idx];
            ready_s[idx] = r;
            if (repulse && (n == 5 || valid_o[idx])) begin
                start_s[idx] = 1'b1;
                value_s[idx] = 32'd55;
            end else begin
                start_s[idx] = 1'b0;
                value_s[idx] = $urandom;
            end
        end
        start_s[idx] = 1'b0;
        ready_s[idx] = 1'b1;
        check({tag, " timeout"}, timeout, 0);
        check({tag, " busy at done"}, busy_o[idx], 0);
        check({tag, " valid at done"}, valid_o[idx], 0);
        @(negedge hwclk);
        check({tag, " done width"}, done_o[idx], 0);
        check({tag, " busy after"}, busy_o[idx], 0);
        check({tag, " digit count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size() && got_q[i] != exp_q[i]) mism++;
        end
        check({tag, " digit values"}, mism, 0);
        check({tag, " first valid"}, run_lat, 33 + 10 - exp_q.size());
        check({tag, " hold"}, hold_err, 0);
        check({tag, " bubbles"}, gap_err, 0);
        check({tag, " last flag"}, last_err, 0);
        check({tag, " busy during"}, busy_err, 0);
        check({tag, " upper bits"}, fmt_err, 0);
    endtask

    initial begin
        int seen;
        tests = 0;
        fails = 0;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0;
            value_s[i] = '0;
            ready_s[i] = 1'b1;
        end

        vecs[0] = '{32'd1234,       0, 0, 1'b0,  4, 39, 1};
        vecs[1] = '{32'd0,          0, 0, 1'b0,  1, 42, 0};
        vecs[2] = '{32'hFFFF_FFFF,  0, 0, 1'b0, 10, 33, 4};
        vecs[3] = '{32'd1234,       1, 0, 1'b0, 10, 33, 0};
        vecs[4] = '{32'd907,        0, 1, 1'b0,  3, 40, 9};
        vecs[5] = '{32'd1234,       0, 0, 1'b1,  4, 39, 1};
        vecs[6] = '{32'd55,         0, 0, 1'b0,  2, 41, 5};
        vecs[7] = '{32'd0,          1, 0, 1'b0, 10, 33, 0};
        vecs[8] = '{32'd1000000000, 0, 2, 1'b0, 10, 33, 1};
        vecs[9] = '{32'd9,          0, 2, 1'b0,  1, 42, 9};

        repeat (3) @(negedge hwclk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset busy%0d", i), busy_o[i], 0);
            check($sformatf("reset valid%0d", i), valid_o[i], 0);
            check($sformatf("reset last%0d", i), last_o[i], 0);
            check($sformatf("reset done%0d", i), done_o[i], 0);
            check($sformatf("reset digit%0d", i), digit_o[i], 0);
        end
        reset = 1'b0;
        @(negedge hwclk);

        for (int v = 0; v < 10; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            run_seq(vecs[v].idx, vecs[v].val, vecs[v].rmode, vecs[v].repulse, tag);
            check({tag, " table count"}, got_q.size(), vecs[v].exp_n);
            check({tag, " table latency"}, run_lat, vecs[v].exp_lat);
            check({tag, " table first"}, (got_q.size() > 0) ? got_q[0] : -1, vecs[v].exp_first);
            $display("[TB] %s value=%0d pad=%0d digits=%0d latency=%0d",
                     tag, vecs[v].val, vecs[v].idx, got_q.size(), run_lat);
        end

        // Reset while the second digit of 1234 is being presented.
        start_s[0] = 1'b1;
        value_s[0] = 32'd1234;
        ready_s[0] = 1'b0;
        @(negedge hwclk);
        start_s[0] = 1'b0;
        seen = 0;
        for (int k = 0; k < 60; k++) begin
            if (valid_o[0]) begin
                seen = 1;
                break;
            end
            @(negedge hwclk);
        end
        check("rst wait valid", seen, 1);
        check("rst first digit", digit_o[0], 1);
        ready_s[0] = 1'b1;
        @(negedge hwclk);
        ready_s[0] = 1'b0;
        check("rst second digit", digit_o[0], 2);
        reset = 1'b1;
        #1;
        check("rst valid drop", valid_o[0], 0);
        check("rst busy drop", busy_o[0], 0);
        check("rst last drop", last_o[0], 0);
        check("rst done low", done_o[0], 0);
        @(negedge hwclk);
        reset = 1'b0;
        ready_s[0] = 1'b1;
        seen = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge hwclk);
            if (valid_o[0] || done_o[0] || busy_o[0]) seen++;
        end
        check("rst quiet after", seen, 0);
        $display("[TB] reset abort checked");
        run_seq(0, 32'd8, 0, 1'b0, "post-reset");
        check("post-reset count", got_q.size(), 1);
        check("post-reset digit", (got_q.size() > 0) ? got_q[0] : -1, 8);
        $display("[TB] post-reset value=8 digits=%0d", got_q.size());

        for (int it = 0; it < 24; it++) begin
            int idx;
            logic [31:0] val;
            idx = $urandom_range(0, 1);
            case ($urandom_range(0, 2))
                0:       val = 32'($urandom_range(0, 99));
                1:       val = 32'($urandom_range(0, 999999));
                default: val = $urandom;
            endcase
            run_seq(idx, val, 2, it[0], $sformatf("rnd%0d", it));
            $display("[TB] rnd%0d value=%0d pad=%0d digits=%0d latency=%0d",
                     it, val, idx, got_q.size(), run_lat);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
